dm_responder: RTL and testbench

- Data-memory responder serving the CPU's MEM stage.
- Replaces the single-cycle data memory with a storage target that answers after a fixed number of wait cycles, using a request/stall/ready handshake.
- The CPU holds its MEM-stage request stable while MemStall is high. It takes read data in the cycle MemReady pulses.
- Storage is byte-addressed, big-endian, and word access only.

---
 rtl/dm_pkg.sv | 12 +
 rtl/dm_word_store.sv | 36 +++
 rtl/dm_responder.sv | 104 ++++++++++
 tb/tb_dm_responder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared encodings and widths for the data-memory responder.
package dm_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int WORD_BYTES = 4;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;

endpackage

// File: rtl/dm_word_store.sv
// Big-endian byte array with one synchronous word write port and one combinational word read port.
// Latency: write lands on the next rising edge; read is same-cycle.
// Backpressure: none, every write is accepted.
module dm_word_store
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WIDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              wrEn,
    input  logic [WIDX_W-1:0] wrWord,
    input  logic [DATA_W-1:0] wrData,
    input  logic [WIDX_W-1:0] rdWord,
    output logic [DATA_W-1:0] rdData
);

    logic [7:0] mem [DEPTH_WORDS*WORD_BYTES];

    // Lane 0 (lowest byte address) carries the most significant byte.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                mem[{wrWord, 2'(b)}] <= wrData[DATA_W-1-8*b -: 8];
            end
        end
    end

    always_comb begin
        rdData = '0;
        for (int b = 0; b < WORD_BYTES; b++) begin
            rdData[DATA_W-1-8*b -: 8] = mem[{rdWord, 2'(b)}];
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder for the MEM stage: word loads/stores after a fixed wait.
// Latency: MemReady pulses LATENCY+1 cycles after the request cycle; LATENCY+2 cycles per access.
// Backpressure: MemStall freezes the requester from the request cycle until the response cycle.
module dm_responder
    import dm_pkg::*;
#(
    parameter int LATENCY     = 3,
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] MemAddr,
    input  logic [31:0] MemWriteData,
    output logic [31:0] MemReadData,
    output logic        MemReady,
    output logic        MemStall,
    output logic        MemErr
);

    localparam int              WIDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH_WORDS * WORD_BYTES);
    localparam logic [3:0]      CNT_LOAD   = 4'(LATENCY - 1);

    logic [1:0]        state;
    logic [3:0]        counter;
    logic [WIDX_W-1:0] latWord;
    logic [DATA_W-1:0] latData;
    logic              latWrite;
    logic [DATA_W-1:0] readReg;
    logic [DATA_W-1:0] storeRdData;
    logic              storeWrEn;

    logic isIdle;
    logic badAddr;
    logic reqOk;
    logic reqErr;

    always_comb begin
        isIdle  = (state == IDLE) && !rst;
        badAddr = (MemAddr[1:0] != 2'b00) || (MemAddr >= ADDR_LIMIT);
        reqOk   = isIdle && (MemRead ^ MemWrite) && !badAddr;
        reqErr  = isIdle && (MemRead || MemWrite) && ((MemRead && MemWrite) || badAddr);
    end

    // A rejected read shows zero in its own cycle; readReg is cleared at the edge so it stays zero.
    assign MemStall    = reqOk || (state == BUSY);
    assign MemReady    = (state == DONE);
    assign MemErr      = reqErr;
    assign MemReadData = (reqErr && MemRead) ? '0 : readReg;

    assign storeWrEn = (state == BUSY) && (counter == 4'd0) && latWrite;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            counter  <= 4'd0;
            latWord  <= '0;
            latData  <= '0;
            latWrite <= 1'b0;
            readReg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (reqOk) begin
                        latWord  <= MemAddr[WIDX_W+1:2];
                        latData  <= MemWriteData;
                        latWrite <= MemWrite;
                        counter  <= CNT_LOAD;
                        state    <= BUSY;
                    end else if (reqErr && MemRead) begin
                        readReg <= '0;
                    end
                end
                BUSY: begin
                    if (counter == 4'd0) begin
                        state <= DONE;
                        if (!latWrite) begin
                            readReg <= storeRdData;
                        end
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    dm_word_store #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .WIDX_W     (WIDX_W)
    ) uStore (
        .clk   (clk),
        .wrEn  (storeWrEn),
        .wrWord(latWord),
        .wrData(latData),
        .rdWord(latWord),
        .rdData(storeRdData)
    );

endmodule

// File: tb/tb_dm_responder.sv
// Randomised and directed checks of dm_responder against a byte-array reference model.
module tb_dm_responder;

    localparam int LAT0  = 3;
    localparam int LAT1  = 1;
    localparam int DEPTH = 64;
    localparam int BYTES = DEPTH * 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        rd0 = 0, wr0 = 0, ready0, stall0, err0;
    logic [31:0] addr0 = 0, wd0 = 0, rdata0;
    logic        rd1 = 0, wr1 = 0, ready1, stall1, err1;
    logic [31:0] addr1 = 0, wd1 = 0, rdata1;

    dm_responder #(.LATENCY(LAT0), .DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .rst(rst), .MemRead(rd0), .MemWrite(wr0), .MemAddr(addr0),
        .MemWriteData(wd0), .MemReadData(rdata0), .MemReady(ready0),
        .MemStall(stall0), .MemErr(err0)
    );

    dm_responder #(.LATENCY(LAT1), .DEPTH_WORDS(DEPTH)) dut1 (
        .clk(clk), .rst(rst), .MemRead(rd1), .MemWrite(wr1), .MemAddr(addr1),
        .MemWriteData(wd1), .MemReadData(rdata1), .MemReady(ready1),
        .MemStall(stall1), .MemErr(err1)
    );

    int passed = 0;
    int total  = 0;

    logic [7:0]  refMem [BYTES];
    logic [31:0] lastRd0;

    function automatic logic [31:0] refRead(input logic [31:0] a);
        return {refMem[a[7:0]], refMem[a[7:0] + 8'd1], refMem[a[7:0] + 8'd2], refMem[a[7:0] + 8'd3]};
    endfunction

    task automatic refWrite(input logic [31:0] a, input logic [31:0] d);
        refMem[a[7:0]]        = d[31:24];
        refMem[a[7:0] + 8'd1] = d[23:16];
        refMem[a[7:0] + 8'd2] = d[15:8];
        refMem[a[7:0] + 8'd3] = d[7:0];
    endtask

    // Drives one request on dut and observes it until MemReady or a rejection (bounded).
    task automatic access0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                           input int altAt, input logic [31:0] altA,
                           output int stalls, output int readyAt, output logic errSeen,
                           output logic stallAtReq, output logic [31:0] rdata);
        @(posedge clk); #1;
        rd0 = r; wr0 = w; addr0 = a; wd0 = d;
        stalls = 0; readyAt = -1; errSeen = 0; stallAtReq = 0; rdata = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (stall0) stalls++;
            if (k == 0) begin
                errSeen = err0; stallAtReq = stall0;
                if (err0) rdata = rdata0;
            end
            if (ready0) begin readyAt = k; rdata = rdata0; break; end
            if (k == 0 && !stall0) break;
            if (k == altAt) begin addr0 = altA; wd0 = ~d; end
        end
        @(posedge clk); #1;
        rd0 = 0; wr0 = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (rdata0 !== 32'h0) $display("FAIL reset_rdata got %h expected 0", rdata0); else passed++;
        total++; if (ready0 !== 1'b0)  $display("FAIL reset_ready got %b expected 0", ready0); else passed++;
        total++; if (stall0 !== 1'b0)  $display("FAIL reset_stall got %b expected 0", stall0); else passed++;
        total++; if (err0 !== 1'b0)    $display("FAIL reset_err got %b expected 0", err0); else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++; if ({ready1, stall1, err1} !== 3'b000 || rdata1 !== 32'h0)
            $display("FAIL reset_dut1 got %b/%h expected 000/0", {ready1, stall1, err1}, rdata1); else passed++;
        lastRd0 = 32'h0;
    endtask

    task automatic test_write_read();
        int st, ra; logic er, sr; logic [31:0] rd;
        access0(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, -1, 0, st, ra, er, sr, rd);
        refWrite(32'h10, 32'hDEADBEEF);
        total++; if (st !== LAT0 + 1) $display("FAIL wr_stalls got %0d expected %0d", st, LAT0 + 1); else passed++;
        total++; if (ra !== LAT0 + 1) $display("FAIL wr_ready_cycle got %0d expected %0d", ra, LAT0 + 1); else passed++;
        total++; if (sr !== 1'b1 || er !== 1'b0) $display("FAIL wr_req_cycle got stall=%b err=%b expected 1/0", sr, er); else passed++;
        total++; if (rd !== lastRd0) $display("FAIL wr_rdata_held got %h expected %h", rd, lastRd0); else passed++;
        access0(1'b1, 1'b0, 32'h10, 32'h0, -1, 0, st, ra, er, sr, rd);
        total++; if (st !== LAT0 + 1) $display("FAIL rd_stalls got %0d expected %0d", st, LAT0 + 1); else passed++;
        total++; if (ra !== LAT0 + 1) $display("FAIL rd_ready_cycle got %0d expected %0d", ra, LAT0 + 1); else passed++;
        total++; if (rd !== 32'hDEADBEEF) $display("FAIL rd_data got %h expected deadbeef", rd); else passed++;
        lastRd0 = 32'hDEADBEEF;
    endtask

    task automatic test_endianness();
        int st, ra; logic er, sr; logic [31:0] rd;
        access0(1'b0, 1'b1, 32'h0, 32'h11223344, -1, 0, st, ra, er, sr, rd);
        refWrite(32'h0, 32'h11223344);
        total++; if (dut.uStore.mem[0] !== 8'h11) $display("FAIL endian_byte0 got %h expected 11", dut.uStore.mem[0]); else passed++;
        total++; if (dut.uStore.mem[3] !== 8'h44) $display("FAIL endian_byte3 got %h expected 44", dut.uStore.mem[3]); else passed++;
        access0(1'b1, 1'b0, 32'h0, 32'h0, -1, 0, st, ra, er, sr, rd);
        total++; if (rd !== 32'h11223344) $display("FAIL endian_read got %h expected 11223344", rd); else passed++;
        lastRd0 = 32'h11223344;
    endtask

    task automatic test_errors();
        int st, ra; logic er, sr; logic [31:0] rd;
        access0(1'b1, 1'b0, 32'h12, 32'h0, -1, 0, st, ra, er, sr, rd);
        total++; if ({er, sr} !== 2'b10 || st !== 0 || ra !== -1 || rd !== 32'h0)
            $display("FAIL err_misaligned got err=%b stall=%b ready=%0d rdata=%h expected 1/0/-1/0", er, sr, ra, rd); else passed++;
        lastRd0 = 32'h0;
        access0(1'b1, 1'b0, 32'h0, 32'h0, -1, 0, st, ra, er, sr, rd);
        total++; if (rd !== 32'h11223344) $display("FAIL err_reload got %h expected 11223344", rd); else passed++;
        access0(1'b1, 1'b0, 32'h100, 32'h0, -1, 0, st, ra, er, sr, rd);
        total++; if ({er, sr} !== 2'b10 || st !== 0 || ra !== -1 || rd !== 32'h0)
            $display("FAIL err_range got err=%b stall=%b ready=%0d rdata=%h expected 1/0/-1/0", er, sr, ra, rd); else passed++;
        access0(1'b0, 1'b1, 32'h20, 32'h55AA0001, -1, 0, st, ra, er, sr, rd);
        refWrite(32'h20, 32'h55AA0001);
        access0(1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, -1, 0, st, ra, er, sr, rd);
        total++; if ({er, sr} !== 2'b10 || ra !== -1)
            $display("FAIL err_both got err=%b stall=%b ready=%0d expected 1/0/-1", er, sr, ra); else passed++;
        access0(1'b1, 1'b0, 32'h20, 32'h0, -1, 0, st, ra, er, sr, rd);
        total++; if (rd !== 32'h55AA0001) $display("FAIL err_both_nowrite got %h expected 55aa0001", rd); else passed++;
        lastRd0 = 32'h55AA0001;
    endtask

    task automatic test_mid_busy_change();
        int st, ra; logic er, sr; logic [31:0] rd;
        access0(1'b1, 1'b0, 32'h10, 32'h0, 1, 32'h20, st, ra, er, sr, rd);
        total++; if (rd !== refRead(32'h10)) $display("FAIL midbusy_data got %h expected %h", rd, refRead(32'h10)); else passed++;
        total++; if (ra !== LAT0 + 1) $display("FAIL midbusy_ready got %0d expected %0d", ra, LAT0 + 1); else passed++;
        lastRd0 = rd;
    endtask

    task automatic test_reset_mid_write();
        int st, ra; logic er, sr; logic [31:0] rd;
        access0(1'b0, 1'b1, 32'h08, 32'h0BADF00D, -1, 0, st, ra, er, sr, rd);
        refWrite(32'h08, 32'h0BADF00D);
        @(posedge clk); #1;
        wr0 = 1'b1; addr0 = 32'h08; wd0 = 32'hCAFEBABE;
        @(negedge clk);
        total++; if (stall0 !== 1'b1) $display("FAIL rstmid_accept got %b expected 1", stall0); else passed++;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        total++; if ({stall0, ready0, err0} !== 3'b000 || rdata0 !== 32'h0)
            $display("FAIL rstmid_outputs got %b/%h expected 000/0", {stall0, ready0, err0}, rdata0); else passed++;
        wr0 = 1'b0;
        @(negedge clk); rst = 1'b0;
        lastRd0 = 32'h0;
        repeat (LAT0 + 2) @(posedge clk);
        access0(1'b1, 1'b0, 32'h08, 32'h0, -1, 0, st, ra, er, sr, rd);
        total++; if (rd !== 32'h0BADF00D) $display("FAIL rstmid_nocommit got %h expected 0badf00d", rd); else passed++;
        lastRd0 = rd;
    endtask

    task automatic test_random();
        int st, ra, kind; logic er, sr, r, w, expErr; logic [31:0] rd, a, d, expRd;
        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom;
            access0(1'b0, 1'b1, 32'(i * 4), d, -1, 0, st, ra, er, sr, rd);
            refWrite(32'(i * 4), d);
            total++; if (er !== 1'b0 || ra !== LAT0 + 1 || rd !== lastRd0)
                $display("FAIL fill_%0d got err=%b ready=%0d rdata=%h expected 0/%0d/%h", i, er, ra, rd, LAT0 + 1, lastRd0); else passed++;
        end
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 9);
            w = 1'($urandom_range(0, 1)); r = !w;
            a = 32'($urandom_range(0, DEPTH - 1) * 4);
            d = $urandom;
            if (kind == 0) begin r = 1'b1; w = 1'b1; end
            else if (kind == 1) a = a | 32'($urandom_range(1, 3));
            else if (kind == 2) a = ($urandom | 32'h100) & ~32'h3;
            expErr = (r && w) || (a[1:0] != 2'b00) || (a >= 32'(BYTES));
            access0(r, w, a, d, -1, 0, st, ra, er, sr, rd);
            if (expErr) begin
                expRd = r ? 32'h0 : lastRd0;
                lastRd0 = expRd;
            end else if (r) begin
                expRd = refRead(a);
                lastRd0 = expRd;
            end else begin
                expRd = lastRd0;
                refWrite(a, d);
            end
            total++; if (er !== expErr || st !== (expErr ? 0 : LAT0 + 1) || ra !== (expErr ? -1 : LAT0 + 1) || rd !== expRd)
                $display("FAIL rand_%0d r=%b w=%b a=%h got err=%b stalls=%0d ready=%0d rdata=%h expected err=%b rdata=%h",
                         i, r, w, a, er, st, ra, rd, expErr, expRd); else passed++;
            @(negedge clk);
            total++; if ({stall0, err0, ready0} !== 3'b000 || rdata0 !== lastRd0)
                $display("FAIL rand_idle_%0d got %b/%h expected 000/%h", i, {stall0, err0, ready0}, rdata0, lastRd0); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic        opR [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] opA [4] = '{32'h0, 32'h4, 32'h0, 32'h4};
        logic [31:0] opD [4];
        logic [31:0] got [4];
        logic [11:0] sv, rv, expS, expR;
        int idx;
        opD[0] = $urandom; opD[1] = $urandom; opD[2] = 0; opD[3] = 0;
        sv = '0; rv = '0; expS = '0; expR = '0; idx = 0;
        for (int j = 0; j < 4; j++) got[j] = 32'hX;
        @(posedge clk); #1;
        rd1 = opR[0]; wr1 = !opR[0]; addr1 = opA[0]; wd1 = opD[0];
        for (int c = 0; c < 12; c++) begin
            expS[c] = (c % 3 != 2);
            expR[c] = (c % 3 == 2);
            @(negedge clk);
            sv[c] = stall1; rv[c] = ready1;
            if (ready1 && idx < 4) begin
                got[idx] = rdata1; idx++;
                @(posedge clk); #1;
                if (idx < 4) begin rd1 = opR[idx]; wr1 = !opR[idx]; addr1 = opA[idx]; wd1 = opD[idx]; end
                else begin rd1 = 0; wr1 = 0; end
            end
        end
        rd1 = 0; wr1 = 0;
        total++; if (sv !== expS) $display("FAIL b2b_stall_pattern got %b expected %b", sv, expS); else passed++;
        total++; if (rv !== expR) $display("FAIL b2b_ready_pattern got %b expected %b", rv, expR); else passed++;
        total++; if (got[1] !== 32'h0) $display("FAIL b2b_write_rdata got %h expected 0", got[1]); else passed++;
        total++; if (got[2] !== opD[0]) $display("FAIL b2b_read0 got %h expected %h", got[2], opD[0]); else passed++;
        total++; if (got[3] !== opD[1]) $display("FAIL b2b_read4 got %h expected %h", got[3], opD[1]); else passed++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout after %0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_endianness();
        test_errors();
        test_mid_busy_change();
        test_reset_mid_write();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
